// File: rtl/irq_nmi_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_nmi_controller
// Description : Interrupt front-end sitting directly upstream of the CPU
//               core's interrupt inputs. It synchronises up to eight
//               peripheral IRQ sources and one NMI source. IRQ sources are
//               masked and can be latched on a rising edge or passed as a
//               level. The block is memory-mapped on the CPU bus and snoops
//               the NMI vector fetch to acknowledge the NMI automatically.
//
// Parameters  : NUM_IRQ      number of IRQ sources (1..8)
//               BASE_ADDR    4-byte aligned register window base
//               SYNC_STAGES  flops per input synchroniser (>= 2)
//
// Ports       : clk                   system clock, rising edge
//               reset                 synchronous, active-high reset
//               irq_src               async peripheral IRQ requests
//               nmi_src               async NMI request (edge-sensitive)
//               addr_hi / addr_lo     CPU address bus
//               data_in               CPU write data
//               read_not_write        1 = read, 0 = write
//               data_out              registered read data
//               data_out_valid        data_out valid for this cycle
//               nonMaskableInterrupt  NMI to core, held until vector fetch
//               interruptRequest      level IRQ to core
//
// Register map (offset = addr_lo[1:0]):
//               0 RAW (RO)   1 MASK (RW)   2 PENDING (R/W1C)   3 EDGE (RW)
//
// Revision    : 1.0  initial release
// ============================================================================

module irq_nmi_controller #(
    parameter int          NUM_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               nmi_src,
    input  logic [7:0]         addr_hi,
    input  logic [7:0]         addr_lo,
    input  logic [7:0]         data_in,
    input  logic               read_not_write,
    output logic [7:0]         data_out,
    output logic               data_out_valid,
    output logic               nonMaskableInterrupt,
    output logic               interruptRequest
);

    localparam logic [15:0] c_NMI_VECTOR = 16'hFFFA;
    localparam int          c_FILL_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [c_FILL_W-1:0] c_FILL_DONE = c_FILL_W'(SYNC_STAGES + 1);

    typedef enum logic [0:0] {
        NMI_IDLE    = 1'b0,
        NMI_PENDING = 1'b1
    } nmiState_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_irqSync;
    logic [SYNC_STAGES-1:0]              r_nmiSync;
    logic [NUM_IRQ-1:0]                  r_irqSd;
    logic                                r_nmiPrev;
    logic [c_FILL_W-1:0]                 r_fillCnt;
    logic [NUM_IRQ-1:0]                  w_irqS;
    logic                                w_nmiS;
    logic                                w_armed;

    assign w_irqS = r_irqSync[SYNC_STAGES-1];
    assign w_nmiS = r_nmiSync[SYNC_STAGES-1];

    // Edge detection is held off until both the synchronised value and its
    // one-cycle-delayed copy contain real post-reset samples. Without this
    // the cleared synchroniser would make a source that was held high
    // through reset look like a fresh rising edge.
    assign w_armed = (r_fillCnt == c_FILL_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqSync <= '0;
            r_nmiSync <= '0;
            r_irqSd   <= '0;
            r_nmiPrev <= 1'b0;
            r_fillCnt <= '0;
        end else begin
            r_irqSync <= {r_irqSync[SYNC_STAGES-2:0], irq_src};
            r_nmiSync <= {r_nmiSync[SYNC_STAGES-2:0], nmi_src};
            r_irqSd   <= w_irqS;
            r_nmiPrev <= w_nmiS;
            if (!w_armed) begin
                r_fillCnt <= r_fillCnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [15:0] w_addr;
    logic        w_hit;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_offset;
    logic        w_vecFetch;

    assign w_addr     = {addr_hi, addr_lo};
    assign w_hit      = (w_addr[15:2] == BASE_ADDR[15:2]);
    assign w_rd       = w_hit &  read_not_write;
    assign w_wr       = w_hit & ~read_not_write;
    assign w_offset   = addr_lo[1:0];
    assign w_vecFetch = read_not_write & (w_addr == c_NMI_VECTOR);

    // ------------------------------------------------------------------
    // MASK / EDGE / edge latches
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_latch;
    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_edgeChg;
    logic [NUM_IRQ-1:0] w_latchNext;

    assign w_pend    = (r_edge & r_latch) | (~r_edge & w_irqS);
    assign w_set     = w_armed ? (r_edge & w_irqS & ~r_irqSd) : '0;
    assign w_w1c     = (w_wr && (w_offset == 2'd2)) ? data_in[NUM_IRQ-1:0] : '0;
    assign w_edgeChg = (w_wr && (w_offset == 2'd3)) ? (data_in[NUM_IRQ-1:0] ^ r_edge) : '0;

    // A new edge beats a W1C on the same bit; switching a bit's mode
    // discards whatever was latched under the old mode.
    assign w_latchNext = ((r_latch & ~w_w1c) | w_set) & ~w_edgeChg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask  <= '0;
            r_edge  <= '0;
            r_latch <= '0;
        end else begin
            r_latch <= w_latchNext;
            if (w_wr && (w_offset == 2'd1)) begin
                r_mask <= data_in[NUM_IRQ-1:0];
            end
            if (w_wr && (w_offset == 2'd3)) begin
                r_edge <= data_in[NUM_IRQ-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: unused high bits read as zero
    // ------------------------------------------------------------------
    logic [7:0] w_rawExt;
    logic [7:0] w_maskExt;
    logic [7:0] w_pendExt;
    logic [7:0] w_edgeExt;
    logic [7:0] w_readData;

    generate
        if (NUM_IRQ < 8) begin : g_pad
            assign w_rawExt  = {{(8-NUM_IRQ){1'b0}}, w_irqS};
            assign w_maskExt = {{(8-NUM_IRQ){1'b0}}, r_mask};
            assign w_pendExt = {{(8-NUM_IRQ){1'b0}}, w_pend};
            assign w_edgeExt = {{(8-NUM_IRQ){1'b0}}, r_edge};
        end else begin : g_full
            assign w_rawExt  = w_irqS;
            assign w_maskExt = r_mask;
            assign w_pendExt = w_pend;
            assign w_edgeExt = r_edge;
        end
    endgenerate

    always_comb begin
        w_readData = 8'h00;
        case (w_offset)
            2'd0:    w_readData = w_rawExt;
            2'd1:    w_readData = w_maskExt;
            2'd2:    w_readData = w_pendExt;
            default: w_readData = w_edgeExt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out         <= 8'h00;
            data_out_valid   <= 1'b0;
            interruptRequest <= 1'b0;
        end else begin
            data_out_valid   <= w_rd;
            interruptRequest <= |(w_pend & r_mask);
            if (w_rd) begin
                data_out <= w_readData;
            end
        end
    end

    // ------------------------------------------------------------------
    // NMI state machine
    // ------------------------------------------------------------------
    nmiState_t r_nmiState;
    nmiState_t w_nmiStateNext;
    logic      w_nmiEdge;

    assign w_nmiEdge = w_armed & w_nmiS & ~r_nmiPrev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nmiState <= NMI_IDLE;
        end else begin
            r_nmiState <= w_nmiStateNext;
        end
    end

    // An edge arriving together with the vector fetch keeps the NMI pending
    // so that request is not lost.
    always_comb begin
        w_nmiStateNext = r_nmiState;
        case (r_nmiState)
            NMI_IDLE: begin
                if (w_nmiEdge) begin
                    w_nmiStateNext = NMI_PENDING;
                end
            end
            default: begin
                if (!w_nmiEdge && w_vecFetch) begin
                    w_nmiStateNext = NMI_IDLE;
                end
            end
        endcase
    end

    assign nonMaskableInterrupt = (r_nmiState == NMI_PENDING);

endmodule

`default_nettype wire

// File: tb/tb_irq_nmi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_nmi_controller
// Description : Self-checking bench for irq_nmi_controller. A behavioural
//               model built on per-source sample histories predicts every
//               output each cycle; directed sequences add literal checks.
// Revision    : 1.0  initial release
// ============================================================================

module tb_irq_nmi_controller;

    localparam int          SYNC = 2;
    localparam logic [15:0] BASE = 16'hD000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_src = 8'h00;
    logic       nmi_src = 1'b0;
    logic [7:0] addr_hi = 8'h00;
    logic [7:0] addr_lo = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       read_not_write = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       nonMaskableInterrupt;
    logic       interruptRequest;

    int nChecks = 0;
    int nErrors = 0;

    irq_nmi_controller #(
        .NUM_IRQ     (8),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .irq_src              (irq_src),
        .nmi_src              (nmi_src),
        .addr_hi              (addr_hi),
        .addr_lo              (addr_lo),
        .data_in              (data_in),
        .read_not_write       (read_not_write),
        .data_out             (data_out),
        .data_out_valid       (data_out_valid),
        .nonMaskableInterrupt (nonMaskableInterrupt),
        .interruptRequest     (interruptRequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: synchronised value = pin sample SYNC clocks ago,
    // an edge needs two genuine post-reset samples.
    // ------------------------------------------------------------------
    bit [7:0]    qIrq[$];
    bit          qNmi[$];
    logic [7:0]  mMask, mEdge, mLatch, mDout, mS, mSd, mPend, mNewLatch;
    logic        mNmi, mIrq, mDvalid, mArmed, mNs, mNp, mHit, mWr, mRd, mFetch;
    logic        mValid = 1'b0;
    logic [15:0] mAddr;
    logic [1:0]  mOff;
    int          mL;

    always @(posedge clk) begin
        if (reset) begin
            qIrq.delete();
            qNmi.delete();
            mMask = 8'h00; mEdge = 8'h00; mLatch = 8'h00; mDout = 8'h00;
            mNmi = 1'b0; mIrq = 1'b0; mDvalid = 1'b0; mValid = 1'b1;
        end else begin
            mL     = qIrq.size();
            mArmed = (mL >= SYNC + 1);
            mS     = (mL >= SYNC) ? qIrq[mL-SYNC] : 8'h00;
            mSd    = mArmed ? qIrq[mL-SYNC-1] : 8'h00;
            mNs    = (mL >= SYNC) ? qNmi[mL-SYNC] : 1'b0;
            mNp    = mArmed ? qNmi[mL-SYNC-1] : 1'b0;
            mAddr  = {addr_hi, addr_lo};
            mHit   = (mAddr[15:2] == BASE[15:2]);
            mRd    = mHit && read_not_write;
            mWr    = mHit && !read_not_write;
            mOff   = addr_lo[1:0];
            mFetch = read_not_write && (mAddr == 16'hFFFA);

            for (int i = 0; i < 8; i++) begin
                mPend[i] = mEdge[i] ? mLatch[i] : mS[i];
            end
            mIrq = |(mPend & mMask);

            if (mRd) begin
                case (mOff)
                    2'd0: mDout = mS;
                    2'd1: mDout = mMask;
                    2'd2: mDout = mPend;
                    default: mDout = mEdge;
                endcase
                mDvalid = 1'b1;
            end else begin
                mDvalid = 1'b0;
            end

            for (int i = 0; i < 8; i++) begin
                if (mWr && mOff == 2'd3 && data_in[i] != mEdge[i])
                    mNewLatch[i] = 1'b0;
                else if (mArmed && mEdge[i] && mS[i] && !mSd[i])
                    mNewLatch[i] = 1'b1;
                else if (mWr && mOff == 2'd2 && data_in[i])
                    mNewLatch[i] = 1'b0;
                else
                    mNewLatch[i] = mLatch[i];
            end
            mLatch = mNewLatch;
            if (mWr && mOff == 2'd1) mMask = data_in;
            if (mWr && mOff == 2'd3) mEdge = data_in;

            if (mArmed && mNs && !mNp) mNmi = 1'b1;
            else if (mFetch)           mNmi = 1'b0;

            qIrq.push_back(irq_src);
            qNmi.push_back(nmi_src);
            if (qIrq.size() > SYNC + 1) void'(qIrq.pop_front());
            if (qNmi.size() > SYNC + 1) void'(qNmi.pop_front());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mValid) begin
            check("model_nmi",    {7'd0, nonMaskableInterrupt}, {7'd0, mNmi});
            check("model_irq",    {7'd0, interruptRequest},     {7'd0, mIrq});
            check("model_dvalid", {7'd0, data_out_valid},       {7'd0, mDvalid});
            check("model_dout",   data_out,                     mDout);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic busIdle();
        {addr_hi, addr_lo} = 16'h0000;
        read_not_write     = 1'b1;
        data_in            = 8'h00;
    endtask

    task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
        {addr_hi, addr_lo} = a;
        read_not_write     = 1'b0;
        data_in            = d;
        tick();
        busIdle();
    endtask

    task automatic busRead(input logic [15:0] a, output logic [7:0] d, output logic v);
        {addr_hi, addr_lo} = a;
        read_not_write     = 1'b1;
        tick();
        d = data_out;
        v = data_out_valid;
        busIdle();
    endtask

    logic [7:0] rd;
    logic       rv;
    logic       prevNmi;
    int         rises;
    int         sel;

    initial begin
        busIdle();
        // 1: reset and idle state
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(5);
        check("rst_nmi", {7'd0, nonMaskableInterrupt}, 8'h00);
        check("rst_irq", {7'd0, interruptRequest}, 8'h00);
        for (int off = 0; off < 4; off++) begin
            busRead(BASE + 16'(off), rd, rv);
            check("rst_reg", rd, 8'h00);
            check("rst_reg_valid", {7'd0, rv}, 8'h01);
        end

        // 2: level IRQ through the mask, with synchroniser latency
        busWrite(BASE + 16'd1, 8'h05);
        irq_src = 8'h02;
        ticks(6);
        check("masked_src_irq", {7'd0, interruptRequest}, 8'h00);
        irq_src = 8'h06;
        ticks(2);
        check("lvl_irq_early", {7'd0, interruptRequest}, 8'h00);
        tick();
        check("lvl_irq_on", {7'd0, interruptRequest}, 8'h01);
        irq_src = 8'h00;
        ticks(4);
        check("lvl_irq_off", {7'd0, interruptRequest}, 8'h00);

        // 3: edge latch, W1C, and W1C racing a new edge
        busWrite(BASE + 16'd3, 8'h01);
        busWrite(BASE + 16'd1, 8'h01);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        ticks(5);
        busRead(BASE + 16'd2, rd, rv);
        check("edge_pending", rd, 8'h01);
        check("edge_irq_held", {7'd0, interruptRequest}, 8'h01);
        busWrite(BASE + 16'd2, 8'h01);
        tick();
        check("w1c_irq_off", {7'd0, interruptRequest}, 8'h00);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        busWrite(BASE + 16'd2, 8'h01);
        tick();
        busRead(BASE + 16'd2, rd, rv);
        check("w1c_vs_edge", rd, 8'h01);
        busWrite(BASE + 16'd2, 8'h01);
        ticks(2);

        // 4: NMI held high fires once; vector fetch acknowledges
        nmi_src = 1'b1;
        prevNmi = 1'b0;
        rises   = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (nonMaskableInterrupt && !prevNmi) rises++;
            prevNmi = nonMaskableInterrupt;
        end
        check("nmi_single_rise", 8'(rises), 8'h01);
        check("nmi_held", {7'd0, nonMaskableInterrupt}, 8'h01);
        busRead(16'hFFFA, rd, rv);
        check("nmi_ack", {7'd0, nonMaskableInterrupt}, 8'h00);
        ticks(20);
        check("nmi_no_reassert", {7'd0, nonMaskableInterrupt}, 8'h00);
        nmi_src = 1'b0;
        ticks(5);
        nmi_src = 1'b1;
        ticks(5);
        check("nmi_retrigger", {7'd0, nonMaskableInterrupt}, 8'h01);
        busRead(16'hFFFA, rd, rv);
        nmi_src = 1'b0;
        ticks(3);

        // 5: register readback, one-cycle valid, window boundary
        busWrite(BASE + 16'd1, 8'hA5);
        busRead(BASE + 16'd1, rd, rv);
        check("mask_readback", rd, 8'hA5);
        check("mask_rd_valid", {7'd0, rv}, 8'h01);
        tick();
        check("valid_one_cycle", {7'd0, data_out_valid}, 8'h00);
        busRead(BASE + 16'd4, rd, rv);
        check("outside_no_valid", {7'd0, rv}, 8'h00);
        busWrite(BASE + 16'd5, 8'h00);
        busRead(BASE + 16'd1, rd, rv);
        check("outside_no_write", rd, 8'hA5);

        // 6: reset while both interrupts are active
        busWrite(BASE + 16'd3, 8'h00);
        busWrite(BASE + 16'd1, 8'h01);
        irq_src = 8'h01;
        nmi_src = 1'b1;
        ticks(5);
        check("pre_rst_irq", {7'd0, interruptRequest}, 8'h01);
        check("pre_rst_nmi", {7'd0, nonMaskableInterrupt}, 8'h01);
        reset = 1'b1;
        tick();
        check("mid_rst_irq", {7'd0, interruptRequest}, 8'h00);
        check("mid_rst_nmi", {7'd0, nonMaskableInterrupt}, 8'h00);
        reset = 1'b0;
        busRead(BASE + 16'd1, rd, rv);
        check("post_rst_mask", rd, 8'h00);
        ticks(10);
        check("held_nmi_no_edge", {7'd0, nonMaskableInterrupt}, 8'h00);
        check("post_rst_irq", {7'd0, interruptRequest}, 8'h00);
        busWrite(BASE + 16'd1, 8'h01);
        tick();
        check("level_reassert", {7'd0, interruptRequest}, 8'h01);
        irq_src = 8'h00;
        nmi_src = 1'b0;
        ticks(4);

        // Randomised traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 15) == 0) irq_src[b] = ~irq_src[b];
            end
            if ($urandom_range(0, 19) == 0) nmi_src = ~nmi_src;
            sel            = int'($urandom_range(0, 9));
            read_not_write = 1'($urandom_range(0, 1));
            data_in        = 8'($urandom);
            if (sel <= 5) begin
                {addr_hi, addr_lo} = BASE + 16'($urandom_range(0, 3));
            end else if (sel == 6) begin
                {addr_hi, addr_lo} = BASE + 16'($urandom_range(4, 7));
            end else if (sel == 7) begin
                {addr_hi, addr_lo} = 16'hFFFA;
                read_not_write     = 1'b1;
            end else begin
                {addr_hi, addr_lo} = 16'h0000;
                read_not_write     = 1'b1;
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        busIdle();
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
